// File: rtl/frame_mem_arbiter.sv
// ---------------------------------------------------------------------------
// frame_mem_arbiter
//
// Purpose:
//   Shares one single-port 320x240 pixel memory between the VGA display read
//   path and a frame-processing engine. The display always wins, so video
//   never misses a pixel. The engine uses every free cycle and raises a
//   starvation flag when it has waited too long. The block also owns the zoom
//   mode register, which only changes on a frame boundary.
//
// Ports:
//   clk_in, rst_n          system clock, asynchronous active-low reset
//   disp_req/disp_addr     display read request and address
//   disp_rdata/disp_rvalid display read data, valid 2 cycles after request
//   eng_req/eng_we         engine request (held until eng_gnt), 1=write
//   eng_addr/eng_wdata     engine address and write data
//   eng_gnt                engine request accepted this cycle (combinational)
//   eng_rdata/eng_rvalid   engine read data, valid 2 cycles after grant
//   eng_starved            engine has waited more than MAX_WAIT cycles
//   mem_addr/mem_we/
//   mem_wdata              registered memory command
//   mem_rdata              memory read data, 1-cycle synchronous read
//   frame_start            one-cycle pulse at the start of each frame
//   zoom_req/zoom_mode     requested and applied zoom code
// ---------------------------------------------------------------------------
module frame_mem_arbiter #(
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 76800,
   parameter int MAX_WAIT  = 1023
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [DATA_W-1:0] eng_wdata,
   output logic              eng_gnt,
   output logic [DATA_W-1:0] eng_rdata,
   output logic              eng_rvalid,
   output logic              eng_starved,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              frame_start,
   input  logic [2:0]        zoom_req,
   output logic [2:0]        zoom_mode
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_ENG  = 2'd2
   } owner_t;

   // Counter must be able to hold MAX_WAIT+1, its saturation value.
   localparam int                CNT_W    = $clog2(MAX_WAIT + 2);
   localparam logic [CNT_W-1:0]  WAIT_SAT = CNT_W'(MAX_WAIT + 1);
   // One extra bit so the bound check still works when MEM_DEPTH == 2**ADDR_W.
   localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

   owner_t            own_next;
   owner_t            own_q;
   owner_t            own_q2;
   logic              rd_q;
   logic              rd_q2;
   logic              oob_q;
   logic              oob_q2;
   logic              disp_oob;
   logic              eng_oob;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_next;
   logic              zoom_legal;

   assign disp_oob = ({1'b0, disp_addr} >= DEPTH);
   assign eng_oob  = ({1'b0, eng_addr} >= DEPTH);

   // Display has absolute priority; the engine only gets cycles it leaves free.
   assign eng_gnt = eng_req & ~disp_req;

   always_comb begin
      own_next = OWN_NONE;
      if (disp_req) begin
         own_next = OWN_DISP;
      end else if (eng_req) begin
         own_next = OWN_ENG;
      end
   end

   // Owner FSM plus memory command issue. The registered owner together with
   // the read and out-of-range flags forms the first tag stage; the second
   // stage lines up with the memory's one-cycle read latency, so read data is
   // steered to the right port exactly two cycles after the request.
   // Out-of-range accesses still occupy the slot but are turned into a
   // harmless read of address 0, and their data is zeroed on return.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         own_q     <= OWN_NONE;
         own_q2    <= OWN_NONE;
         rd_q      <= 1'b0;
         rd_q2     <= 1'b0;
         oob_q     <= 1'b0;
         oob_q2    <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         own_q  <= own_next;
         own_q2 <= own_q;
         rd_q2  <= rd_q;
         oob_q2 <= oob_q;
         case (own_next)
            OWN_DISP: begin
               mem_we   <= 1'b0;
               mem_addr <= disp_oob ? '0 : disp_addr;
               rd_q     <= 1'b1;
               oob_q    <= disp_oob;
            end
            OWN_ENG: begin
               mem_we    <= eng_we & ~eng_oob;
               mem_addr  <= eng_oob ? '0 : eng_addr;
               mem_wdata <= eng_wdata;
               rd_q      <= ~eng_we;
               oob_q     <= eng_oob;
            end
            default: begin
               mem_we <= 1'b0;
               rd_q   <= 1'b0;
               oob_q  <= 1'b0;
            end
         endcase
      end
   end

   assign disp_rvalid = rd_q2 & (own_q2 == OWN_DISP);
   assign eng_rvalid  = rd_q2 & (own_q2 == OWN_ENG);
   assign disp_rdata  = (disp_rvalid && !oob_q2) ? mem_rdata : '0;
   assign eng_rdata   = (eng_rvalid && !oob_q2) ? mem_rdata : '0;

   // Wait counter: counts cycles the engine is held off, saturating so it can
   // never wrap back below the threshold; a grant clears it.
   always_comb begin
      wait_next = wait_cnt;
      if (eng_gnt) begin
         wait_next = '0;
      end else if (eng_req && (wait_cnt != WAIT_SAT)) begin
         wait_next = wait_cnt + CNT_W'(1);
      end
   end

   // Starved flag is registered from the next count so it rises in the same
   // cycle the stored count first exceeds MAX_WAIT.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         eng_starved <= 1'b0;
      end else begin
         wait_cnt    <= wait_next;
         eng_starved <= (wait_next == WAIT_SAT);
      end
   end

   // Only normal, 2x and 4x codes are meaningful; anything else is dropped so
   // a bad request can never put the address datapath in an undefined mode.
   assign zoom_legal = (zoom_req == 3'b000) || (zoom_req == 3'b010) ||
                       (zoom_req == 3'b100);

   // Zoom only changes on frame boundaries so a frame is never split.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         zoom_mode <= 3'b000;
      end else if (frame_start && zoom_legal) begin
         zoom_mode <= zoom_req;
      end
   end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_mem_arbiter
//
// Purpose:
//   Self-checking bench for frame_mem_arbiter. Directed scenarios cover reset,
//   display streaming, engine write/read, contention, bounds, starvation,
//   zoom and reset during a read; a randomized run is checked against a
//   behavioural model built from response queues and a golden pixel image.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_frame_mem_arbiter;

   localparam int ADDR_W    = 17;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 76800;
   localparam int MAX_WAIT  = 4;

   logic              clk_in;
   logic              rst_n;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;
   logic              eng_req;
   logic              eng_we;
   logic [ADDR_W-1:0] eng_addr;
   logic [DATA_W-1:0] eng_wdata;
   logic              eng_gnt;
   logic [DATA_W-1:0] eng_rdata;
   logic              eng_rvalid;
   logic              eng_starved;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              frame_start;
   logic [2:0]        zoom_req;
   logic [2:0]        zoom_mode;

   int vectors;
   int miscompares;

   frame_mem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MEM_DEPTH(MEM_DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_rdata (disp_rdata),
      .disp_rvalid(disp_rvalid),
      .eng_req    (eng_req),
      .eng_we     (eng_we),
      .eng_addr   (eng_addr),
      .eng_wdata  (eng_wdata),
      .eng_gnt    (eng_gnt),
      .eng_rdata  (eng_rdata),
      .eng_rvalid (eng_rvalid),
      .eng_starved(eng_starved),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .frame_start(frame_start),
      .zoom_req   (zoom_req),
      .zoom_mode  (zoom_mode)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Memory model: unwritten pixels read back as addr[7:0].
   logic [7:0] mem     [0:131071];
   bit         written [0:131071];

   always @(posedge clk_in) begin
      if (mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : mem_addr[7:0];
   end

   // Golden image used by the reference model.
   logic [7:0] gd [0:131071];
   bit         gw [0:131071];

   function automatic logic [7:0] gold(input logic [ADDR_W-1:0] a);
      return gw[a] ? gd[a] : a[7:0];
   endfunction

   typedef struct {
      int         due;
      logic [7:0] data;
   } resp_t;

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      disp_req    = 1'b0;
      eng_req     = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      disp_addr = '0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
      zoom_req = 3'b000;
      repeat (2) next_cycle();
      vectors++;
      if ({disp_rvalid, disp_rdata, eng_gnt, eng_rdata, eng_rvalid, eng_starved} !== '0) begin
         miscompares++;
         $display("FAIL reset_ports got dv=%0b dd=%0h g=%0b ed=%0h ev=%0b st=%0b exp all 0",
                  disp_rvalid, disp_rdata, eng_gnt, eng_rdata, eng_rvalid, eng_starved);
      end
      vectors++;
      if ({mem_addr, mem_we, mem_wdata, zoom_mode} !== '0) begin
         miscompares++;
         $display("FAIL reset_mem got addr=%0d we=%0b wd=%0h zoom=%0b exp all 0",
                  mem_addr, mem_we, mem_wdata, zoom_mode);
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_display();
      for (int i = 0; i < 6; i++) begin
         disp_req  = (i < 3);
         disp_addr = ADDR_W'(i);
         @(negedge clk_in);
         vectors++;
         if (disp_rvalid !== (i >= 2 && i <= 4)) begin
            miscompares++;
            $display("FAIL disp_rvalid cyc=%0d got=%0b exp=%0b", i, disp_rvalid, (i >= 2 && i <= 4));
         end
         if (i >= 2 && i <= 4) begin
            vectors++;
            if (disp_rdata !== 8'(i - 2)) begin
               miscompares++;
               $display("FAIL disp_rdata cyc=%0d got=%0h exp=%0h", i, disp_rdata, 8'(i - 2));
            end
         end
         vectors++;
         if (mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_mem_we cyc=%0d got=%0b exp=0", i, mem_we);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_engine_rw();
      eng_req = 1'b1; eng_we = 1'b1; eng_addr = 17'd100; eng_wdata = 8'hA5;
      @(negedge clk_in);
      vectors++;
      if (eng_gnt !== 1'b1) begin
         miscompares++; $display("FAIL eng_gnt_wr got=%0b exp=1", eng_gnt);
      end
      gw[100] = 1'b1; gd[100] = 8'hA5;
      next_cycle();
      eng_we = 1'b0;
      @(negedge clk_in);
      vectors++;
      if (eng_gnt !== 1'b1) begin
         miscompares++; $display("FAIL eng_gnt_rd got=%0b exp=1", eng_gnt);
      end
      vectors++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'd100, 8'hA5}) begin
         miscompares++;
         $display("FAIL eng_wr_issue got we=%0b addr=%0d wd=%0h exp we=1 addr=100 wd=a5",
                  mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
      eng_req = 1'b0;
      @(negedge clk_in);
      vectors++;
      if (eng_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL eng_wr_rvalid got=%0b exp=0", eng_rvalid);
      end
      next_cycle();
      @(negedge clk_in);
      vectors++;
      if ({eng_rvalid, eng_rdata} !== {1'b1, 8'hA5}) begin
         miscompares++;
         $display("FAIL eng_rd_data got v=%0b d=%0h exp v=1 d=a5", eng_rvalid, eng_rdata);
      end
      next_cycle();
   endtask

   task automatic test_contention();
      eng_we = 1'b0; eng_addr = 17'd7;
      for (int i = 0; i < 9; i++) begin
         disp_req  = (i < 5);
         disp_addr = ADDR_W'(10 + i);
         eng_req   = (i <= 5);
         @(negedge clk_in);
         if (i <= 5) begin
            vectors++;
            if (eng_gnt !== (i == 5)) begin
               miscompares++;
               $display("FAIL cont_gnt cyc=%0d got=%0b exp=%0b", i, eng_gnt, (i == 5));
            end
         end
         vectors++;
         if ({disp_rvalid, eng_rvalid} !== {(i >= 2 && i <= 6), (i == 7)}) begin
            miscompares++;
            $display("FAIL cont_valid cyc=%0d got dv=%0b ev=%0b exp dv=%0b ev=%0b",
                     i, disp_rvalid, eng_rvalid, (i >= 2 && i <= 6), (i == 7));
         end
         if (i >= 2 && i <= 6) begin
            vectors++;
            if (disp_rdata !== 8'(10 + i - 2)) begin
               miscompares++;
               $display("FAIL cont_disp_data cyc=%0d got=%0h exp=%0h", i, disp_rdata, 8'(10 + i - 2));
            end
         end
         if (i == 7) begin
            vectors++;
            if (eng_rdata !== 8'h07) begin
               miscompares++;
               $display("FAIL cont_eng_data got=%0h exp=07", eng_rdata);
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_bounds();
      // Make address 0 nonzero so an unmasked out-of-range read is visible.
      eng_req = 1'b1; eng_we = 1'b1; eng_addr = 17'd0; eng_wdata = 8'h5A;
      gw[0] = 1'b1; gd[0] = 8'h5A;
      next_cycle();
      eng_addr = 17'd76800; eng_wdata = 8'hFF;
      @(negedge clk_in);
      vectors++;
      if (eng_gnt !== 1'b1) begin
         miscompares++; $display("FAIL oob_gnt got=%0b exp=1", eng_gnt);
      end
      next_cycle();
      eng_req = 1'b0; disp_req = 1'b1; disp_addr = 17'd76800;
      @(negedge clk_in);
      vectors++;
      if ({mem_we, mem_addr} !== {1'b0, 17'd0}) begin
         miscompares++;
         $display("FAIL oob_wr_issue got we=%0b addr=%0d exp we=0 addr=0", mem_we, mem_addr);
      end
      next_cycle();
      disp_req = 1'b0; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 17'd76805;
      @(negedge clk_in);
      vectors++;
      if ({mem_we, mem_addr, eng_rvalid} !== {1'b0, 17'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL oob_rd_issue got we=%0b addr=%0d ev=%0b exp 0 0 0", mem_we, mem_addr, eng_rvalid);
      end
      next_cycle();
      eng_req = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({disp_rvalid, disp_rdata} !== {1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL oob_disp_data got v=%0b d=%0h exp v=1 d=00", disp_rvalid, disp_rdata);
      end
      next_cycle();
      @(negedge clk_in);
      vectors++;
      if ({eng_rvalid, eng_rdata} !== {1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL oob_eng_data got v=%0b d=%0h exp v=1 d=00", eng_rvalid, eng_rdata);
      end
      next_cycle();
   endtask

   task automatic test_starvation();
      eng_we = 1'b0; eng_addr = 17'd3;
      for (int i = 0; i < 12; i++) begin
         disp_req  = (i < 10);
         disp_addr = ADDR_W'(20 + i);
         eng_req   = (i <= 10);
         @(negedge clk_in);
         vectors++;
         if (eng_starved !== (i >= 5 && i <= 10)) begin
            miscompares++;
            $display("FAIL starved cyc=%0d got=%0b exp=%0b", i, eng_starved, (i >= 5 && i <= 10));
         end
         if (i <= 10) begin
            vectors++;
            if (eng_gnt !== (i == 10)) begin
               miscompares++;
               $display("FAIL starve_gnt cyc=%0d got=%0b exp=%0b", i, eng_gnt, (i == 10));
            end
         end
         next_cycle();
      end
      idle_inputs();
      repeat (3) next_cycle();
   endtask

   task automatic test_zoom();
      logic [2:0] codes [4];
      logic       fs    [4];
      logic [2:0] expz  [4];
      codes = '{3'b100, 3'b100, 3'b111, 3'b010};
      fs    = '{1'b0, 1'b1, 1'b1, 1'b1};
      expz  = '{3'b000, 3'b100, 3'b100, 3'b010};
      for (int i = 0; i < 4; i++) begin
         zoom_req    = codes[i];
         frame_start = fs[i];
         next_cycle();
         frame_start = 1'b0;
         @(negedge clk_in);
         vectors++;
         if (zoom_mode !== expz[i]) begin
            miscompares++;
            $display("FAIL zoom step=%0d got=%0b exp=%0b", i, zoom_mode, expz[i]);
         end
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      disp_req = 1'b1; disp_addr = 17'd5;
      next_cycle();
      disp_req = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({mem_addr, mem_we, mem_wdata, zoom_mode, eng_starved, disp_rvalid, eng_rvalid} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset got addr=%0d we=%0b wd=%0h zoom=%0b st=%0b dv=%0b ev=%0b exp all 0",
                  mem_addr, mem_we, mem_wdata, zoom_mode, eng_starved, disp_rvalid, eng_rvalid);
      end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         vectors++;
         if ({disp_rvalid, eng_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset_rvalid cyc=%0d got dv=%0b ev=%0b exp 0 0", i, disp_rvalid, eng_rvalid);
         end
         next_cycle();
      end
   endtask

   task automatic test_random();
      resp_t      dq[$];
      resp_t      eq[$];
      resp_t      r;
      int         waits;
      logic [2:0] exp_zoom;
      logic       exp_gnt;
      logic       exp_dv;
      logic       exp_ev;
      bit         in_rng;
      waits    = 0;
      exp_zoom = 3'b000;
      idle_inputs();
      for (int cyc = 0; cyc < 1504; cyc++) begin
         if (cyc < 1500) begin
            disp_req  = ($urandom_range(99) < 55);
            disp_addr = ($urandom_range(15) == 0) ? ADDR_W'(MEM_DEPTH + $urandom_range(99))
                                                  : ADDR_W'($urandom_range(63));
            if (!eng_req && $urandom_range(1) == 1) begin
               eng_req   = 1'b1;
               eng_we    = $urandom_range(1) == 1;
               eng_addr  = ($urandom_range(15) == 0) ? ADDR_W'(MEM_DEPTH + $urandom_range(99))
                                                     : ADDR_W'($urandom_range(63));
               eng_wdata = 8'($urandom);
            end
            frame_start = ($urandom_range(19) == 0);
            zoom_req    = 3'($urandom_range(7));
         end else begin
            disp_req    = 1'b0;
            frame_start = 1'b0;
         end
         @(negedge clk_in);
         exp_gnt = eng_req && !disp_req;
         exp_dv  = (dq.size() > 0) && (dq[0].due == cyc);
         exp_ev  = (eq.size() > 0) && (eq[0].due == cyc);
         vectors++;
         if (eng_gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL rnd_gnt cyc=%0d got=%0b exp=%0b", cyc, eng_gnt, exp_gnt);
         end
         vectors++;
         if (disp_rvalid !== exp_dv) begin
            miscompares++;
            $display("FAIL rnd_disp_rvalid cyc=%0d got=%0b exp=%0b", cyc, disp_rvalid, exp_dv);
         end
         if (exp_dv) begin
            r = dq.pop_front();
            vectors++;
            if (disp_rdata !== r.data) begin
               miscompares++;
               $display("FAIL rnd_disp_rdata cyc=%0d got=%0h exp=%0h", cyc, disp_rdata, r.data);
            end
         end
         vectors++;
         if (eng_rvalid !== exp_ev) begin
            miscompares++;
            $display("FAIL rnd_eng_rvalid cyc=%0d got=%0b exp=%0b", cyc, eng_rvalid, exp_ev);
         end
         if (exp_ev) begin
            r = eq.pop_front();
            vectors++;
            if (eng_rdata !== r.data) begin
               miscompares++;
               $display("FAIL rnd_eng_rdata cyc=%0d got=%0h exp=%0h", cyc, eng_rdata, r.data);
            end
         end
         vectors++;
         if (eng_starved !== (waits > MAX_WAIT)) begin
            miscompares++;
            $display("FAIL rnd_starved cyc=%0d got=%0b exp=%0b", cyc, eng_starved, (waits > MAX_WAIT));
         end
         vectors++;
         if (zoom_mode !== exp_zoom) begin
            miscompares++;
            $display("FAIL rnd_zoom cyc=%0d got=%0b exp=%0b", cyc, zoom_mode, exp_zoom);
         end
         // Model update: who owns this cycle's slot and what it returns.
         if (disp_req) begin
            in_rng = (int'(disp_addr) < MEM_DEPTH);
            r.due  = cyc + 2;
            r.data = in_rng ? gold(disp_addr) : 8'h00;
            dq.push_back(r);
         end else if (eng_req) begin
            in_rng = (int'(eng_addr) < MEM_DEPTH);
            if (eng_we) begin
               if (in_rng) begin
                  gw[eng_addr] = 1'b1;
                  gd[eng_addr] = eng_wdata;
               end
            end else begin
               r.due  = cyc + 2;
               r.data = in_rng ? gold(eng_addr) : 8'h00;
               eq.push_back(r);
            end
         end
         if (exp_gnt) begin
            waits = 0;
         end else if (eng_req) begin
            waits = (waits + 1 > MAX_WAIT + 1) ? MAX_WAIT + 1 : waits + 1;
         end
         if (frame_start && (zoom_req == 3'b000 || zoom_req == 3'b010 || zoom_req == 3'b100)) begin
            exp_zoom = zoom_req;
         end
         next_cycle();
         if (exp_gnt) eng_req = 1'b0;
      end
      idle_inputs();
      vectors++;
      if (dq.size() + eq.size() != 0) begin
         miscompares++;
         $display("FAIL rnd_drain got=%0d outstanding exp=0", dq.size() + eq.size());
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_display();
      test_engine_rw();
      test_contention();
      test_bounds();
      test_starvation();
      test_zoom();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
